// File: rtl/meas_frame_packer.sv
// Snapshots the four measurement counts and streams them as one framed, checksummed
// 20-byte record (sync pair, sequence number, 16 big-endian data bytes, XOR checksum).
module meas_frame_packer #(
    parameter logic [7:0] HDR0   = 8'h55,
    parameter logic [7:0] HDR1   = 8'hAA,
    parameter int         DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              meas_valid,
    input  logic [31:0]       cnt_clk,
    input  logic [31:0]       cnt_square,
    input  logic [31:0]       cnt_pulse,
    input  logic [31:0]       cnt_time,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_SEQ  = 3'd3,
        S_DATA = 3'd4,
        S_CHK  = 3'd5
    } state_t;

    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    state_t      state_r;
    logic [3:0]  idx_r;
    logic [31:0] snap_clk_r;
    logic [31:0] snap_square_r;
    logic [31:0] snap_pulse_r;
    logic [31:0] snap_time_r;
    logic [7:0]  seq_r;
    logic [7:0]  chk_r;

    // Data byte idx of the snapshot: word idx[3:2], most significant byte first.
    function automatic logic [7:0] pick_byte(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2, input logic [31:0] w3,
                                             input logic [3:0] idx);
        logic [31:0] w;
        logic [7:0]  b;
        case (idx[3:2])
            2'd0:    w = w0;
            2'd1:    w = w1;
            2'd2:    w = w2;
            2'd3:    w = w3;
            default: w = 32'h0000_0000;
        endcase
        case (idx[1:0])
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Running XOR checksum fold.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Frame sequencer: every output is registered; the next byte is loaded on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            idx_r         <= 4'd0;
            snap_clk_r    <= 32'h0000_0000;
            snap_square_r <= 32'h0000_0000;
            snap_pulse_r  <= 32'h0000_0000;
            snap_time_r   <= 32'h0000_0000;
            seq_r         <= 8'h00;
            chk_r         <= 8'h00;
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            drop_cnt      <= {DROP_W{1'b0}};
        end else begin
            frame_done <= 1'b0;
            // Busy is registered, so a strobe in the frame_done cycle is accepted, not dropped.
            if (busy && meas_valid && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + DROP_ONE;
            end
            case (state_r)
                S_IDLE: begin
                    if (meas_valid) begin
                        snap_clk_r    <= cnt_clk;
                        snap_square_r <= cnt_square;
                        snap_pulse_r  <= cnt_pulse;
                        snap_time_r   <= cnt_time;
                        chk_r         <= seq_r;
                        tx_data       <= HDR0;
                        tx_valid      <= 1'b1;
                        busy          <= 1'b1;
                        state_r       <= S_HDR0;
                    end else begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                S_HDR0: begin
                    if (tx_ready) begin
                        tx_data <= HDR1;
                        state_r <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (tx_ready) begin
                        tx_data <= seq_r;
                        state_r <= S_SEQ;
                    end
                end
                S_SEQ: begin
                    if (tx_ready) begin
                        idx_r   <= 4'd0;
                        tx_data <= pick_byte(snap_clk_r, snap_square_r, snap_pulse_r,
                                             snap_time_r, 4'd0);
                        state_r <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_ready) begin
                        chk_r <= chk_fold(chk_r, tx_data);
                        if (idx_r == 4'd15) begin
                            tx_data <= chk_fold(chk_r, tx_data);
                            state_r <= S_CHK;
                        end else begin
                            idx_r   <= idx_r + 4'd1;
                            tx_data <= pick_byte(snap_clk_r, snap_square_r, snap_pulse_r,
                                                 snap_time_r, idx_r + 4'd1);
                        end
                    end
                end
                S_CHK: begin
                    if (tx_ready) begin
                        tx_data    <= 8'h00;
                        tx_valid   <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        seq_r      <= seq_r + 8'd1;
                        state_r    <= S_IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_meas_frame_packer.sv
// Scoreboard bench for meas_frame_packer: stimulus pushes expected bytes, a monitor pops
// and compares them on every accepted transfer.
module tb_meas_frame_packer;

    logic        clk;
    logic        rst_n;
    logic        meas_valid;
    logic [31:0] cnt_clk;
    logic [31:0] cnt_square;
    logic [31:0] cnt_pulse;
    logic [31:0] cnt_time;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    meas_frame_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .meas_valid (meas_valid),
        .cnt_clk    (cnt_clk),
        .cnt_square (cnt_square),
        .cnt_pulse  (cnt_pulse),
        .cnt_time   (cnt_time),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic       last_q[$];
    int         xfer_cnt = 0;
    int         ready_mode = 0;
    logic [7:0] seq_m = 8'h00;
    int         drop_m = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] s, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        logic [127:0] d;
        logic [7:0]   c;
        logic [7:0]   b;
        d = {w0, w1, w2, w3};
        c = s;
        exp_q.push_back(8'h55); last_q.push_back(1'b0);
        exp_q.push_back(8'hAA); last_q.push_back(1'b0);
        exp_q.push_back(s);     last_q.push_back(1'b0);
        for (int i = 0; i < 16; i++) begin
            b = d[127 - 8*i -: 8];
            c = c ^ b;
            exp_q.push_back(b); last_q.push_back(1'b0);
        end
        exp_q.push_back(c); last_q.push_back(1'b1);
    endtask

    task automatic pulse();
        meas_valid = 1'b1;
        @(posedge clk); #1;
        meas_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(posedge clk); #1;
            if (frame_done) seen = 1'b1;
        end
        check("frame_done_timeout", {31'd0, seen}, 32'd1);
    endtask

    // tx_ready driver: always high, random ~30% high, or held low.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ($urandom_range(0, 99) < 30);
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: byte compare, hold-stable check while stalled, frame_done timing.
    initial begin
        logic       stall_prev;
        logic [7:0] stall_data;
        logic       exp_done;
        logic [7:0] e;
        logic       l;
        stall_prev = 1'b0;
        stall_data = 8'h00;
        exp_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_done) begin
                check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
                exp_done = 1'b0;
            end else if (frame_done) begin
                check("frame_done_spurious", {31'd0, frame_done}, 32'd0);
            end
            if (stall_prev && tx_valid) check("tx_data_stable", {24'd0, tx_data}, {24'd0, stall_data});
            if (tx_valid && tx_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    l = last_q.pop_front();
                    check("frame_byte", {24'd0, tx_data}, {24'd0, e});
                    if (l) exp_done = 1'b1;
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    initial begin
        logic [7:0] t1_bytes[20];
        int         base;
        logic       hit;
        t1_bytes = '{8'h55, 8'hAA, 8'h00, 8'h05, 8'hF5, 8'hE1, 8'h00, 8'h00, 8'h00, 8'h03,
                     8'hE8, 8'h00, 8'h00, 8'h00, 8'h32, 8'h12, 8'h34, 8'h56, 8'h78, 8'hC0};
        rst_n = 1'b0; meas_valid = 1'b0;
        cnt_clk = 32'd0; cnt_square = 32'd0; cnt_pulse = 32'd0; cnt_time = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: hand-computed frame, inputs scrambled after capture.
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(t1_bytes[i]);
            last_q.push_back(i == 19);
        end
        cnt_clk = 32'h05F5E100; cnt_square = 32'h000003E8;
        cnt_pulse = 32'h00000032; cnt_time = 32'h12345678;
        pulse();
        check("t1_hdr0_after_capture", {23'd0, busy, tx_data}, {23'd0, 1'b1, 8'h55});
        cnt_clk = 32'hDEADBEEF; cnt_square = 32'hCAFEF00D; cnt_pulse = 32'h0; cnt_time = 32'h1;
        wait_done(40);
        check("t1_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        seq_m = 8'h01;

        // Test 4: strobe in the frame_done cycle starts the next frame at once.
        cnt_clk = 32'h11223344; cnt_square = 32'h55667788;
        cnt_pulse = 32'h99AABBCC; cnt_time = 32'hDDEEFF00;
        push_frame(seq_m, cnt_clk, cnt_square, cnt_pulse, cnt_time);
        pulse();
        check("t4_hdr0_next_cycle", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h55});
        wait_done(40);
        check("t4_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        seq_m++;

        // Test 2: random backpressure.
        ready_mode = 1;
        @(posedge clk); #1;
        cnt_clk = 32'h05F5E100; cnt_square = 32'h000003E8;
        cnt_pulse = 32'h00000032; cnt_time = 32'h12345678;
        push_frame(seq_m, cnt_clk, cnt_square, cnt_pulse, cnt_time);
        pulse();
        wait_done(2000);
        ready_mode = 0;
        seq_m++;
        repeat (2) @(posedge clk);
        #1;

        // Test 3: strobes during a frame are dropped; then saturation.
        cnt_clk = 32'hA1A2A3A4; cnt_square = 32'hB1B2B3B4;
        cnt_pulse = 32'hC1C2C3C4; cnt_time = 32'hD1D2D3D4;
        push_frame(seq_m, cnt_clk, cnt_square, cnt_pulse, cnt_time);
        pulse();
        for (int k = 0; k < 3; k++) begin
            cnt_clk = 32'h0BAD0000 + k; cnt_time = 32'hFFFF0000 + k;
            @(posedge clk); #1;
            pulse();
        end
        drop_m = 3;
        wait_done(40);
        check("t3_drop_cnt_3", {24'd0, drop_cnt}, drop_m);
        seq_m++;
        ready_mode = 2;
        @(posedge clk); @(posedge clk); #1;
        push_frame(seq_m, cnt_clk, cnt_square, cnt_pulse, cnt_time);
        meas_valid = 1'b1;
        repeat (261) @(posedge clk);
        #1;
        meas_valid = 1'b0;
        drop_m = (drop_m + 260 > 255) ? 255 : drop_m + 260;
        check("t3_drop_cnt_sat", {24'd0, drop_cnt}, drop_m);
        check("t3_stalled_hdr0", {22'd0, busy, tx_valid, tx_data}, {22'd0, 2'b11, 8'h55});
        ready_mode = 0;
        wait_done(40);
        seq_m++;

        // Test 5: 256 back-to-back frames, sequence wraps.
        for (int f = 0; f < 256; f++) begin
            cnt_clk = {f[7:0], 24'h010203}; cnt_square = ~{24'd0, f[7:0]};
            cnt_pulse = 32'h5A5A0000 ^ f; cnt_time = {f[7:0], f[7:0], 16'hC3C3};
            push_frame(seq_m, cnt_clk, cnt_square, cnt_pulse, cnt_time);
            pulse();
            wait_done(40);
            seq_m++;
        end
        check("t5_drop_cnt", {24'd0, drop_cnt}, drop_m);

        // Test 6: asynchronous reset mid-frame, then a fresh frame with SEQ=00.
        @(posedge clk); #1;
        base = xfer_cnt;
        push_frame(seq_m, 32'h76543210, 32'hFEDCBA98, 32'h0F0F0F0F, 32'hF0F0F0F0);
        cnt_clk = 32'h76543210; cnt_square = 32'hFEDCBA98;
        cnt_pulse = 32'h0F0F0F0F; cnt_time = 32'hF0F0F0F0;
        pulse();
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (xfer_cnt >= base + 7) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("t6_reach_byte7", {31'd0, hit}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        last_q.delete();
        check("t6_async_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        check("t6_async_tx_data", {24'd0, tx_data}, 32'd0);
        check("t6_async_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        seq_m = 8'h00;
        drop_m = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cnt_clk = 32'h00000001; cnt_square = 32'h00000002;
        cnt_pulse = 32'h00000003; cnt_time = 32'h00000004;
        push_frame(seq_m, cnt_clk, cnt_square, cnt_pulse, cnt_time);
        pulse();
        wait_done(40);
        check("t6_drop_cnt", {24'd0, drop_cnt}, drop_m);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
